// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, opcodes and queue entry type for the fetch stage
package fetch_pkg;
   localparam int INSTR_W = 16;
   localparam int PC_W    = 16;
   localparam int OPC_LSB = 0;
   localparam int OPC_MSB = 3;
   localparam logic [3:0] OP_HALT = 4'hF;
   localparam logic [3:0] OP_NOOP = 4'h0;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } fetch_entry_t;

   function automatic logic [3:0] opcode(input logic [INSTR_W-1:0] i);
      return i[OPC_MSB:OPC_LSB];
   endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, decoder and redirect signals of the fetch stage
interface fetch_unit_if;
   import fetch_pkg::*;
   logic               imem_en;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_data;
   logic               out_valid;
   logic [INSTR_W-1:0] out_instr;
   logic [PC_W-1:0]    out_pc;
   logic               out_ready;
   logic               redirect_valid;
   logic [PC_W-1:0]    redirect_pc;
   logic               halted;

   modport master (
      output imem_en, imem_addr, out_valid, out_instr, out_pc, halted,
      input  imem_data, out_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_en, imem_addr, out_valid, out_instr, out_pc, halted,
      output imem_data, out_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of fetched instructions; flush overrides push and pop
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  fetch_entry_t             push_data,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;
   fetch_entry_t  mem_q [DEPTH];

   // next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
   always_comb begin
      rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
      wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
      count_d  = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
   end

   // pointer and occupancy registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage is not reset; only slots below count are ever presented as valid
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= push_data;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, 1-cycle imem reads, instruction queue, redirect and halt handling
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input logic         clk,
   input logic         rst,
   fetch_unit_if.master io
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [PC_W-1:0] pc_q, pc_d, ipc_q, ipc_d;
   logic            inflight_q, inflight_d, halted_q, halted_d;
   logic            issue, push, pop, halt_pop, flush, valid;
   logic [PC_W-1:0] addr;
   logic [CW-1:0]   count;
   fetch_entry_t    head, ret;

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push),
      .pop       (pop),
      .push_data (ret),
      .head      (head),
      .count     (count)
   );

   // issue credit covers queued plus in-flight entries and ignores a same-cycle pop, so the queue cannot overflow
   always_comb begin
      issue      = !halted_q && (io.redirect_valid || (({1'b0, count} + (CW+1)'(inflight_q)) < (CW+1)'(DEPTH)));
      addr       = io.redirect_valid ? io.redirect_pc : pc_q;
      valid      = (count != '0) && !io.redirect_valid && !halted_q;
      pop        = valid && io.out_ready;
      halt_pop   = pop && (opcode(head.instr) == OP_HALT);
      flush      = io.redirect_valid || halt_pop;
      push       = inflight_q && !io.redirect_valid && !halted_q;
      ret        = '{instr: io.imem_data, pc: ipc_q};
      pc_d       = issue ? addr + 1'b1 : pc_q;
      ipc_d      = issue ? addr : ipc_q;
      inflight_d = issue;
      halted_d   = halted_q || halt_pop;
   end

   // PC, in-flight tracking and the sticky halt flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         ipc_q      <= '0;
         inflight_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         ipc_q      <= ipc_d;
         inflight_q <= inflight_d;
         halted_q   <= halted_d;
      end
   end

   assign io.imem_en   = issue;
   assign io.imem_addr = addr;
   assign io.out_valid = valid;
   assign io.out_instr = head.instr;
   assign io.out_pc    = head.pc;
   assign io.halted    = halted_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a scoreboard of expected decoder-side pops
module tb_fetch_unit;
   import fetch_pkg::*;

   logic clk, rst, rst2;
   logic [15:0] halt_addr;
   int n_vec = 0;
   int n_err = 0;
   fetch_entry_t exp_q[$];
   fetch_entry_t exp2_q[$];
   fetch_entry_t e1, e2;

   fetch_unit_if bus ();
   fetch_unit_if bus2 ();

   fetch_unit u_dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   fetch_unit #(.RESET_PC(16'hFFFE)) u_wrap (
      .clk (clk),
      .rst (rst2),
      .io  (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (a == halt_addr) return 16'h000F;
      return (16'h1000 + a) ^ ((a[3:0] == 4'hF) ? 16'h0001 : 16'h0000);
   endfunction

   // synchronous instruction memories, one-cycle read latency
   always @(posedge clk) if (bus.imem_en) bus.imem_data <= mem_word(bus.imem_addr);
   always @(posedge clk) if (bus2.imem_en) bus2.imem_data <= {bus2.imem_addr[7:0], 8'h21};

   // scoreboard monitor for the main instance
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL pop: got pc %h instr %h, expected no pop", bus.out_pc, bus.out_instr);
         end else begin
            e1 = exp_q.pop_front();
            if (bus.out_pc !== e1.pc || bus.out_instr !== e1.instr) begin
               n_err++;
               $display("FAIL pop: got pc %h instr %h, expected pc %h instr %h", bus.out_pc, bus.out_instr, e1.pc, e1.instr);
            end
         end
      end
   end

   // scoreboard monitor for the wrap-around instance
   always @(negedge clk) begin
      if (!rst2 && bus2.out_valid && bus2.out_ready) begin
         n_vec++;
         if (exp2_q.size() == 0) begin
            n_err++;
            $display("FAIL wrap pop: got pc %h instr %h, expected no pop", bus2.out_pc, bus2.out_instr);
         end else begin
            e2 = exp2_q.pop_front();
            if (bus2.out_pc !== e2.pc || bus2.out_instr !== e2.instr) begin
               n_err++;
               $display("FAIL wrap pop: got pc %h instr %h, expected pc %h instr %h", bus2.out_pc, bus2.out_instr, e2.pc, e2.instr);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [15:0] a);
      exp_q.push_back('{instr: mem_word(a), pc: a});
   endtask

   initial begin
      rst = 1'b1;
      rst2 = 1'b1;
      halt_addr = 16'h004A;
      bus.out_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      bus2.out_ready = 1'b1;
      bus2.redirect_valid = 1'b0;
      bus2.redirect_pc = '0;
      repeat (2) tick();
      #1;
      chk("rst out_valid", bus.out_valid, 0);
      chk("rst halted", bus.halted, 0);
      chk("rst imem_addr", bus.imem_addr, 0);
      // streaming from reset: pops 0..9 in cycles 2..11
      for (int i = 0; i < 10; i++) push_exp(16'(i));
      tick();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      chk("c0 imem_addr", bus.imem_addr, 0);
      chk("c0 imem_en", bus.imem_en, 1);
      chk("c0 out_valid", bus.out_valid, 0);
      tick();
      #1;
      chk("c1 imem_addr", bus.imem_addr, 1);
      chk("c1 out_valid", bus.out_valid, 0);
      tick();
      #1;
      chk("c2 out_valid", bus.out_valid, 1);
      chk("c2 imem_addr", bus.imem_addr, 2);
      repeat (9) tick();
      // backpressure for 10 cycles: queue holds 10..13, pc parked at 14
      tick();
      bus.out_ready = 1'b0;
      repeat (9) tick();
      #1;
      chk("stall imem_en", bus.imem_en, 0);
      chk("stall imem_addr", bus.imem_addr, 16'h000E);
      chk("stall out_valid", bus.out_valid, 1);
      // resume for 6 cycles: pops 10..15, then stall again with 16..19 queued
      for (int i = 10; i < 16; i++) push_exp(16'(i));
      tick();
      bus.out_ready = 1'b1;
      repeat (5) tick();
      tick();
      bus.out_ready = 1'b0;
      repeat (5) tick();
      #1;
      chk("stall2 imem_en", bus.imem_en, 0);
      chk("stall2 imem_addr", bus.imem_addr, 16'h0014);
      // redirect to 0x40 with a full queue; stream runs into the halt at 0x4A
      for (int i = 0; i < 11; i++) push_exp(16'h0040 + 16'(i));
      tick();
      bus.out_ready = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 16'h0040;
      #1;
      chk("redir imem_en", bus.imem_en, 1);
      chk("redir imem_addr", bus.imem_addr, 16'h0040);
      chk("redir out_valid", bus.out_valid, 0);
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      chk("redir+1 out_valid", bus.out_valid, 0);
      chk("redir+1 imem_addr", bus.imem_addr, 16'h0041);
      tick();
      #1;
      chk("redir+2 out_valid", bus.out_valid, 1);
      repeat (10) tick();
      #1;
      chk("halt-pop cycle halted", bus.halted, 0);
      tick();
      #1;
      chk("halted", bus.halted, 1);
      chk("halted imem_en", bus.imem_en, 0);
      chk("halted out_valid", bus.out_valid, 0);
      tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 16'h0080;
      #1;
      chk("halted redir imem_en", bus.imem_en, 0);
      chk("halted redir out_valid", bus.out_valid, 0);
      tick();
      bus.redirect_valid = 1'b0;
      repeat (3) tick();
      #1;
      chk("still halted", bus.halted, 1);
      chk("still halted imem_en", bus.imem_en, 0);
      chk("halt stream drained", exp_q.size(), 0);
      // asynchronous reset clears halt immediately
      #1;
      rst = 1'b1;
      #1;
      chk("async rst halted", bus.halted, 0);
      chk("async rst out_valid", bus.out_valid, 0);
      chk("async rst imem_addr", bus.imem_addr, 0);
      // halt at pc 3 popped in the same cycle as a redirect to 0x10: redirect wins
      halt_addr = 16'h0003;
      for (int i = 0; i < 3; i++) push_exp(16'(i));
      for (int i = 0; i < 6; i++) push_exp(16'h0010 + 16'(i));
      tick();
      rst = 1'b0;
      repeat (5) tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 16'h0010;
      #1;
      chk("collide head instr", bus.out_instr, 16'h000F);
      chk("collide imem_addr", bus.imem_addr, 16'h0010);
      chk("collide out_valid", bus.out_valid, 0);
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      chk("collide halted", bus.halted, 0);
      repeat (6) tick();
      tick();
      bus.out_ready = 1'b0;
      repeat (3) tick();
      #1;
      chk("collide halted later", bus.halted, 0);
      chk("collide stream drained", exp_q.size(), 0);
      // wrap-around instance starting at 0xFFFE
      exp2_q.push_back('{instr: 16'hFE21, pc: 16'hFFFE});
      exp2_q.push_back('{instr: 16'hFF21, pc: 16'hFFFF});
      exp2_q.push_back('{instr: 16'h0021, pc: 16'h0000});
      exp2_q.push_back('{instr: 16'h0121, pc: 16'h0001});
      tick();
      rst2 = 1'b0;
      #1;
      chk("wrap c0 addr", bus2.imem_addr, 16'hFFFE);
      tick();
      #1;
      chk("wrap c1 addr", bus2.imem_addr, 16'hFFFF);
      tick();
      #1;
      chk("wrap c2 addr", bus2.imem_addr, 16'h0000);
      tick();
      #1;
      chk("wrap c3 addr", bus2.imem_addr, 16'h0001);
      repeat (2) tick();
      tick();
      rst2 = 1'b1;
      #1;
      chk("wrap stream drained", exp2_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Generates the PC and issues reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned 16-bit instructions, with their PCs, in a small queue and presents them to the decoder over a valid/ready handshake.
- Handles redirects from the jump/cjump units and stops fetching permanently once a halt instruction (opcode 4'hF) is consumed.

Parameters:
- PC_W, 16: PC and instruction-memory word-address width.
- DEPTH, 4: instruction queue entries; power of two, ≥2.
- RESET_PC, 0: first fetch address after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_en  out  1  instruction memory read enable.
- imem_addr  out  PC_W  word address of the read.
- imem_data  in  16  read data; valid in the cycle after imem_en was high.
- out_valid  out  1  queue head is valid.
- out_instr  out  16  queue-head instruction, to the decoder.
- out_pc  out  PC_W  PC of out_instr.
- out_ready  in  1  decoder/dispatch accepts the head this cycle.
- redirect_valid  in  1  control-flow redirect request.
- redirect_pc  in  PC_W  redirect target.
- halted  out  1  fetch stopped by a consumed halt.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - pc=RESET_PC; queue count, read pointer and write pointer = 0; inflight=0; halted=0.
  - Hence out_valid=0, halted=0, imem_addr=RESET_PC.
- Word addressing: pc advances by 1 per issue and wraps modulo 2^PC_W (0xFFFF -> 0x0000).
- Issue condition:
  - imem_en = !halted && (redirect_valid || (count + inflight < DEPTH)).
  - imem_addr = redirect_valid ? redirect_pc : pc.
  - On issue, pc <= imem_addr + 1 and inflight <= 1; otherwise inflight <= 0.
  - The credit check ignores any same-cycle pop, so the queue can never overflow.
- Return path:
  - If inflight=1 and there is no redirect this cycle, {imem_data, issued PC} is written to the queue at the clock edge.
  - Issued PC is kept in a 1-entry register alongside inflight.
- Output:
  - out_valid = (count != 0) && !redirect_valid && !halted.
  - The head is popped on out_valid && out_ready.
  - Push and pop may occur in the same cycle; count is then unchanged.
- Latency: read issued in cycle N -> queued at the end of N+1 -> out_valid in N+2.
- Throughput: 1 instr/cycle sustained with out_ready held high.
- Redirect (redirect_valid=1):
  - Flush the queue: count and pointers reset.
  - Discard the in-flight return.
  - Issue redirect_pc in the same cycle.
  - The first target instruction appears on out_valid 2 cycles later.
  - A pop is not performed in the redirect cycle (out_valid is masked).
- Halt:
  - On a pop whose out_instr[3:0]==OP_HALT, and with no redirect that cycle: halted <= 1 and the queue is flushed.
  - While halted: imem_en=0, out_valid=0, redirects ignored. Only rst clears halted.
- Redirect and halt-pop in the same cycle: redirect wins. No pop occurs and halted stays 0, because the halt is wrong-path.
- Reset mid-stream: all state clears immediately, the in-flight return is dropped, and fetch restarts at RESET_PC.

Decomposition:
- fetch_pkg contains:
  - INSTR_W=16.
  - OPCODE field slice [3:0].
  - OP_HALT=4'hF, OP_NOOP=4'h0.
  - typedef fetch_entry_t {instr[15:0], pc[PC_W-1:0]}.
- One sub-module, fetch_queue: synchronous circular FIFO of fetch_entry_t with push, pop, flush, count, and head output.
- pc, inflight and halted logic live in fetch_unit.

Test Plan:
- Reset, then out_ready=1, imem returns data[a]=16'h1000+a -> imem_addr sequence 0,1,2,…; out_valid first high 2 cycles after reset release; out_instr 1000,1001,… every cycle with out_pc matching.
- Hold out_ready=0 for 10 cycles -> count reaches 4, imem_en drops to 0, no entry lost or duplicated; release -> stream resumes in order.
- redirect_valid=1, redirect_pc=0x0040 while queue is non-empty -> same-cycle imem_addr=0x0040; no stale instruction emitted; next out_pc=0x0040 two cycles later.
- Queue head 16'h000F popped -> halted=1 next cycle; imem_en=0 and out_valid=0 thereafter; a later redirect has no effect; rst clears it and fetch restarts at RESET_PC.
- Halt at head popped in the same cycle as redirect_pc=0x0010 -> halted stays 0; fetch resumes at 0x0010.
- RESET_PC=16'hFFFE -> addresses FFFE, FFFF, 0000, 0001; out_pc wraps identically.
